// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: single-port memory arbiter between fetch and data ports, fixed read latency.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN. Rev 1.0
`default_nettype none

module arm_mem_arbiter #(
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        i_req,
   input  logic [29:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [29:0] d_addr,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_write_en,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        mem_busy
);

   localparam logic [3:0] LAT_INIT = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] cnt;
   logic       owner_data;
   logic       data_wins;
   logic       any_req;

   assign any_req = i_req | d_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
   logic [3:0] starve;

   // Fetch is forced through once data has won STARVE_MAX times in a row over it.
   assign data_wins = d_req & ~(i_req & (starve == STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         starve <= 4'h0;
      end else if (state == IDLE) begin
         if (i_req && data_wins)
            starve <= starve + 4'h1;
         else
            starve <= 4'h0;
      end
   end
`else
   assign data_wins = d_req;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = BUSY;
         BUSY:    if (cnt == 4'h1) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= IDLE;
         cnt          <= 4'h0;
         owner_data   <= 1'b0;
         mem_addr     <= 30'h0;
         mem_write_en <= 4'h0;
         mem_data_in  <= 32'h0;
         i_rdata      <= 32'h0;
         d_rdata      <= 32'h0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_data <= data_wins;
                  cnt        <= LAT_INIT;
                  if (data_wins) begin
                     mem_addr     <= d_addr;
                     mem_write_en <= d_we;
                     mem_data_in  <= d_wdata;
                  end else begin
                     mem_addr     <= i_addr;
                     mem_write_en <= 4'h0;
                  end
               end
            end
            BUSY: begin
               // Enables live for the first BUSY cycle only so a store lands once.
               mem_write_en <= 4'h0;
               cnt          <= cnt - 4'h1;
               if (cnt == 4'h1) begin
                  if (owner_data)
                     d_rdata <= mem_data_out;
                  else
                     i_rdata <= mem_data_out;
               end
            end
            default: ;
         endcase
      end
   end

   assign i_done   = (state == DONE) & ~owner_data;
   assign d_done   = (state == DONE) &  owner_data;
   assign mem_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_arm_mem_arbiter.sv
// Scoreboard bench for arm_mem_arbiter: transaction-level reference model plus decoupled monitor.
`default_nettype none

module tb_arm_mem_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 2;

   logic        clk;
   logic        rst_b;
   logic        i_req;
   logic [29:0] i_addr;
   logic        i_done;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [29:0] d_addr;
   logic [3:0]  d_we;
   logic [31:0] d_wdata;
   logic        d_done;
   logic [31:0] d_rdata;
   logic [29:0] mem_addr;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        mem_busy;

   arm_mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_done       (i_done),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_addr       (d_addr),
      .d_we         (d_we),
      .d_wdata      (d_wdata),
      .d_done       (d_done),
      .d_rdata      (d_rdata),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .mem_busy     (mem_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte lane 0 (enable bit 3) is the most significant byte.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                         input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (we[3-k]) r[31-8*k -: 8] = wd[31-8*k -: 8];
      return r;
   endfunction

   logic [31:0] mem [64];
   logic [31:0] shadow [64];

   always @(posedge clk)
      if (mem_write_en != 4'h0)
         mem[mem_addr[5:0]] <= merge(mem[mem_addr[5:0]], mem_write_en, mem_data_in);

   assign mem_data_out = mem[mem_addr[5:0]];

   typedef struct {
      logic        data;
      logic        store;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          free_at = 0;
   int          g_cyc = -100;
   logic        g_data = 1'b0;
   logic [3:0]  g_we = 4'h0;
   logic [29:0] g_addr = 30'h0;
   logic [31:0] g_wdata = 32'h0;
`ifdef MEM_ARB_STARVE_GUARD_EN
   int          starve = 0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: one access at a time, LAT+2 cycles each, data first unless fetch starves.
   initial forever begin
      exp_t e;
      logic pick_d;
      @(posedge clk);
      if (rst_b && cyc >= free_at) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         if (!i_req) starve = 0;
`endif
         if (i_req || d_req) begin
            pick_d = d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (i_req && starve == SMAX) pick_d = 1'b0;
            if (pick_d && i_req) starve++;
            else starve = 0;
`endif
            e.data  = pick_d;
            e.store = pick_d && (d_we != 4'h0);
            e.cyc   = cyc + LAT + 1;
            if (pick_d) begin
               g_addr  = d_addr;
               g_we    = d_we;
               g_wdata = d_wdata;
               if (e.store) shadow[d_addr[5:0]] = merge(shadow[d_addr[5:0]], d_we, d_wdata);
               e.rdata = shadow[d_addr[5:0]];
            end else begin
               g_addr  = i_addr;
               g_we    = 4'h0;
               e.rdata = shadow[i_addr[5:0]];
            end
            g_data  = pick_d;
            g_cyc   = cyc;
            free_at = cyc + LAT + 2;
            q.push_back(e);
         end
      end
      cyc++;
   end

   // Monitor: compares every cycle's memory-side behaviour and pops on each done pulse.
   initial forever begin
      exp_t e;
      logic busy_e;
      @(negedge clk);
      busy_e = (cyc > g_cyc) && (cyc <= g_cyc + LAT + 1);
      chk("mem_busy", 32'(mem_busy), 32'(busy_e));
      chk("mem_write_en", 32'(mem_write_en), (cyc == g_cyc + 1 && g_data) ? 32'(g_we) : 32'h0);
      if (busy_e) begin
         chk("mem_addr", 32'(mem_addr), 32'(g_addr));
         if (g_data) chk("mem_data_in", mem_data_in, g_wdata);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         chk("missing_done", 32'(cyc), 32'(e.cyc));
      end
      if (i_done || d_done) begin
         if (q.size() == 0) begin
            chk("spurious_done", {30'h0, i_done, d_done}, 32'h0);
         end else begin
            e = q.pop_front();
            chk("done_owner", {30'h0, i_done, d_done}, e.data ? 32'h1 : 32'h2);
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            if (!e.store) chk(e.data ? "d_rdata" : "i_rdata", e.data ? d_rdata : i_rdata, e.rdata);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((i_req || d_req) && n < 60) begin
         tick();
         n++;
      end
      if (i_req || d_req) begin
         chk("request_timeout", {30'h0, i_req, d_req}, 32'h0);
         i_req = 1'b0;
         d_req = 1'b0;
      end
   endtask

   task automatic raise_d();
      d_req   = 1'b1;
      d_addr  = 30'($urandom_range(0, 63));
      d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d_wdata = $urandom;
   endtask

   task automatic raise_i();
      i_req  = 1'b1;
      i_addr = 30'($urandom_range(0, 63));
   endtask

   initial begin
      rst_b = 1'b0; i_req = 1'b0; d_req = 1'b0;
      i_addr = 30'h0; d_addr = 30'h0; d_we = 4'h0; d_wdata = 32'h0;
      for (int k = 0; k < 64; k++) begin
         mem[k]    = $urandom;
         shadow[k] = mem[k];
      end
      mem[16]    = 32'hE3A00001;
      shadow[16] = 32'hE3A00001;
      repeat (2) @(negedge clk);
      chk("reset_i_rdata", i_rdata, 32'h0);
      chk("reset_d_rdata", d_rdata, 32'h0);
      chk("reset_mem_addr", 32'(mem_addr), 32'h0);
      chk("reset_mem_data_in", mem_data_in, 32'h0);
      chk("reset_flags", {25'h0, mem_busy, i_done, d_done, mem_write_en}, 32'h0);
      rst_b = 1'b1;

      // Single fetch with a known instruction word.
      tick(); i_req = 1'b1; i_addr = 30'h10;
      wait_idle();
      chk("fetch_word", i_rdata, 32'hE3A00001);

      // Byte store then a load of the same word.
      tick(); d_req = 1'b1; d_addr = 30'h5; d_we = 4'b0100; d_wdata = 32'hABABABAB;
      wait_idle();
      tick(); d_req = 1'b1; d_we = 4'h0;
      wait_idle();

      // Simultaneous load and fetch.
      tick(); i_req = 1'b1; i_addr = 30'h3; d_req = 1'b1; d_addr = 30'h9; d_we = 4'h0;
      wait_idle();

      // Both ports held continuously: exercises strict priority or the starvation guard.
      for (int c = 0; c < 40; c++) begin
         tick();
         if (!i_req) raise_i();
         if (!d_req) begin raise_d(); d_we = 4'h0; end
      end
      wait_idle();

      // Reset asserted while a load is in flight.
      tick(); d_req = 1'b1; d_addr = 30'h7; d_we = 4'h0;
      tick();
      @(posedge clk);
      #2;
      rst_b = 1'b0; d_req = 1'b0;
      q.delete(); g_cyc = -100; free_at = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve = 0;
`endif
      #1;
      chk("reset_mid_busy", 32'(mem_busy), 32'h0);
      chk("reset_mid_done", {30'h0, i_done, d_done}, 32'h0);
      tick(); tick();
      @(posedge clk);
      #2;
      rst_b = 1'b1;
      tick(); i_req = 1'b1; i_addr = 30'h10;
      wait_idle();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         tick();
         if (!i_req && $urandom_range(0, 2) == 0) raise_i();
         if (!d_req && $urandom_range(0, 2) == 0) raise_d();
      end
      wait_idle();
      repeat (6) tick();
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
